// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - multi-channel down-counting timer bank with shared prescaler and interrupt aggregation
module timer_bank #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 32,
   parameter int PRESC_W = 8
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic [PRESC_W-1:0]      prescale_i,
   input  logic [NUM_CH-1:0]       ch_enable_i,
   input  logic [2*NUM_CH-1:0]     ch_mode_i,
   input  logic [NUM_CH*CNT_W-1:0] ch_load_count_i,
   input  logic [NUM_CH-1:0]       irq_mask_i,
   input  logic [NUM_CH-1:0]       irq_clear_i,
   output logic [NUM_CH*CNT_W-1:0] ch_current_value_o,
   output logic [NUM_CH-1:0]       ch_done_o,
   output logic [NUM_CH-1:0]       irq_status_o,
   output logic                    interrupt_o
);

   localparam logic [1:0] MODE_FREE    = 2'b00;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               tick;
   logic               any_en;
   logic [NUM_CH-1:0]  en_q;
   logic [CNT_W-1:0]   cnt_q [NUM_CH];
   logic [CNT_W-1:0]   cnt_d [NUM_CH];
   logic [CNT_W-1:0]   reload_val [NUM_CH];
   logic [NUM_CH-1:0]  done_q, done_d;
   logic [NUM_CH-1:0]  stat_q, stat_d;
   logic [NUM_CH-1:0]  expire;

   // Shared prescaler: counts while any channel runs, ticks when it reaches prescale and wraps.
   // A prescale lowered below the current count lets the count run on through its natural wrap.
   always_comb begin
      any_en  = |ch_enable_i;
      tick    = 1'b0;
      presc_d = presc_q;
      if (!any_en) begin
         presc_d = '0;
      end else if (presc_q == prescale_i) begin
         tick    = 1'b1;
         presc_d = '0;
      end else begin
         presc_d = presc_q + {{(PRESC_W-1){1'b0}}, 1'b1};
      end
   end

   // Value loaded on an enable edge or expiry: all-ones for free-run, otherwise the channel's load count.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         reload_val[i] = (ch_mode_i[2*i +: 2] == MODE_FREE) ? {CNT_W{1'b1}}
                                                           : ch_load_count_i[i*CNT_W +: CNT_W];
      end
   end

   // Per-channel next state: load beats stop, stop beats tick; expiry sets status over a clear.
   always_comb begin
      expire = '0;
      done_d = done_q;
      stat_d = stat_q;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (ch_enable_i[i] && !en_q[i]) begin
            cnt_d[i]  = reload_val[i];
            done_d[i] = 1'b0;
         end else if (!ch_enable_i[i] || done_q[i]) begin
            cnt_d[i] = cnt_q[i];
         end else if (tick) begin
            if (cnt_q[i] != '0) begin
               cnt_d[i] = cnt_q[i] - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               expire[i] = 1'b1;
               if (ch_mode_i[2*i +: 2] == MODE_ONESHOT) begin
                  cnt_d[i]  = '0;
                  done_d[i] = 1'b1;
               end else begin
                  cnt_d[i] = reload_val[i];
               end
            end
         end
         if (expire[i]) begin
            stat_d[i] = 1'b1;
         end else if (irq_clear_i[i]) begin
            stat_d[i] = 1'b0;
         end
      end
   end

   // State registers; reset parks counters at all-ones with everything else idle.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         presc_q <= '0;
         en_q    <= '0;
         done_q  <= '0;
         stat_q  <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= {CNT_W{1'b1}};
         end
      end else begin
         presc_q <= presc_d;
         en_q    <= ch_enable_i;
         done_q  <= done_d;
         stat_q  <= stat_d;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Outputs come straight from registers so the interrupt line cannot glitch on counter activity.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         ch_current_value_o[i*CNT_W +: CNT_W] = cnt_q[i];
      end
      ch_done_o    = done_q;
      irq_status_o = stat_q;
      interrupt_o  = |(stat_q & irq_mask_i);
   end

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - directed self-checking bench for timer_bank
module tb_timer_bank;

   localparam int NUM_CH  = 2;
   localparam int CNT_W   = 8;
   localparam int PRESC_W = 8;

   logic                    clk_i = 1'b0;
   logic                    rstn_i;
   logic [PRESC_W-1:0]      prescale_i;
   logic [NUM_CH-1:0]       ch_enable_i;
   logic [2*NUM_CH-1:0]     ch_mode_i;
   logic [NUM_CH*CNT_W-1:0] ch_load_count_i;
   logic [NUM_CH-1:0]       irq_mask_i;
   logic [NUM_CH-1:0]       irq_clear_i;
   logic [NUM_CH*CNT_W-1:0] ch_current_value_o;
   logic [NUM_CH-1:0]       ch_done_o;
   logic [NUM_CH-1:0]       irq_status_o;
   logic                    interrupt_o;

   int n_total = 0;
   int n_bad   = 0;

   timer_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
      .clk_i              (clk_i),
      .rstn_i             (rstn_i),
      .prescale_i         (prescale_i),
      .ch_enable_i        (ch_enable_i),
      .ch_mode_i          (ch_mode_i),
      .ch_load_count_i    (ch_load_count_i),
      .irq_mask_i         (irq_mask_i),
      .irq_clear_i        (irq_clear_i),
      .ch_current_value_o (ch_current_value_o),
      .ch_done_o          (ch_done_o),
      .irq_status_o       (irq_status_o),
      .interrupt_o        (interrupt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [7:0] v0();
      return ch_current_value_o[7:0];
   endfunction

   function automatic logic [7:0] v1();
      return ch_current_value_o[15:8];
   endfunction

   int exp_p [5] = '{3, 2, 1, 0, 3};
   int exp_s [5] = '{0, 0, 0, 0, 1};

   initial begin
      rstn_i          = 1'b0;
      prescale_i      = '0;
      ch_enable_i     = '0;
      ch_mode_i       = '0;
      ch_load_count_i = '0;
      irq_mask_i      = '0;
      irq_clear_i     = '0;
      step();
      step();
      check("rst_v0", v0(), 8'hFF);
      check("rst_v1", v1(), 8'hFF);
      check("rst_stat", irq_status_o, 0);
      check("rst_done", ch_done_o, 0);
      check("rst_irq", interrupt_o, 0);
      rstn_i = 1'b1;
      step();

      // periodic ch0, load 3, prescale 0
      ch_mode_i[1:0]       = 2'b01;
      ch_load_count_i[7:0] = 8'd3;
      irq_mask_i           = 2'b01;
      ch_enable_i[0]       = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("per_v%0d", k), v0(), exp_p[k]);
         check($sformatf("per_s%0d", k), irq_status_o[0], exp_s[k]);
      end
      check("per_irq", interrupt_o, 1);

      // clear on a non-expiry cycle
      irq_clear_i[0] = 1'b1;
      step();
      irq_clear_i[0] = 1'b0;
      check("clr_stat", irq_status_o[0], 0);
      check("clr_v", v0(), 2);
      check("clr_irq", interrupt_o, 0);
      step();
      step();
      check("pre_exp_v", v0(), 0);
      // clear coincident with expiry: set wins
      irq_clear_i[0] = 1'b1;
      step();
      irq_clear_i[0] = 1'b0;
      check("setwin_stat", irq_status_o[0], 1);
      check("setwin_v", v0(), 3);

      // masking drops interrupt without touching status
      irq_mask_i[0] = 1'b0;
      #1;
      check("mask_irq", interrupt_o, 0);
      check("mask_stat", irq_status_o[0], 1);
      irq_mask_i[0] = 1'b1;
      #1;
      check("unmask_irq", interrupt_o, 1);

      // load change takes effect at next reload
      ch_load_count_i[7:0] = 8'd9;
      step();
      check("ld_chg_v", v0(), 2);
      step();
      step();
      step();
      check("ld_reload_v", v0(), 9);
      for (int k = 0; k < 4; k++) step();
      check("pre_dis_v", v0(), 5);

      // disable freezes; re-enable loads fresh
      ch_enable_i[0] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (k == 4 || k == 9) check($sformatf("dis_v%0d", k), v0(), 5);
      end
      ch_enable_i[0] = 1'b1;
      step();
      check("reen_v", v0(), 9);
      ch_enable_i[0] = 1'b0;
      step();

      // one-shot, prescale 2, load 1
      prescale_i           = 8'd2;
      ch_mode_i[1:0]       = 2'b10;
      ch_load_count_i[7:0] = 8'd1;
      irq_clear_i[0]       = 1'b1;
      ch_enable_i[0]       = 1'b1;
      step();
      irq_clear_i[0] = 1'b0;
      check("os_load_v", v0(), 1);
      check("os_load_s", irq_status_o[0], 0);
      step();
      check("os_hold_v", v0(), 1);
      step();
      check("os_dec_v", v0(), 0);
      step();
      step();
      check("os_pre_done", ch_done_o[0], 0);
      step();
      check("os_done", ch_done_o[0], 1);
      check("os_stat", irq_status_o[0], 1);
      check("os_v", v0(), 0);
      irq_clear_i[0] = 1'b1;
      step();
      irq_clear_i[0] = 1'b0;
      for (int k = 0; k < 6; k++) step();
      check("os_after_v", v0(), 0);
      check("os_after_done", ch_done_o[0], 1);
      check("os_after_stat", irq_status_o[0], 0);
      ch_enable_i[0] = 1'b0;
      step();
      check("os_dis_done", ch_done_o[0], 1);
      ch_enable_i[0] = 1'b1;
      step();
      check("os_reen_v", v0(), 1);
      check("os_reen_done", ch_done_o[0], 0);
      ch_enable_i[0] = 1'b0;
      step();

      // free-run ch1, prescale 0
      prescale_i     = 8'd0;
      ch_mode_i[3:2] = 2'b00;
      irq_mask_i     = 2'b11;
      ch_enable_i[1] = 1'b1;
      step();
      check("fr_load_v", v1(), 255);
      step();
      check("fr_dec_v", v1(), 254);
      for (int k = 0; k < 254; k++) step();
      check("fr_zero_v", v1(), 0);
      check("fr_zero_s", irq_status_o[1], 0);
      step();
      check("fr_wrap_v", v1(), 255);
      check("fr_wrap_s", irq_status_o[1], 1);
      check("fr_irq", interrupt_o, 1);

      // async reset mid-count on both channels
      ch_mode_i[1:0]       = 2'b01;
      ch_load_count_i[7:0] = 8'd3;
      ch_enable_i          = 2'b11;
      step();
      step();
      check("pre_rst_v0", v0(), 2);
      rstn_i = 1'b0;
      #1;
      check("mid_rst_v0", v0(), 8'hFF);
      check("mid_rst_v1", v1(), 8'hFF);
      check("mid_rst_stat", irq_status_o, 0);
      check("mid_rst_done", ch_done_o, 0);
      check("mid_rst_irq", interrupt_o, 0);
      ch_enable_i = 2'b00;
      step();
      rstn_i = 1'b1;
      step();
      step();
      check("post_rst_hold", v0(), 8'hFF);
      ch_enable_i[0] = 1'b1;
      step();
      check("post_rst_load", v0(), 3);
      check("post_rst_v1", v1(), 8'hFF);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Multi-channel down-counting timer bank for the peripheral subsystem. Generalises the single 32-bit timer with parametrised channel count and counter width.
- Adds a shared clock prescaler, three counting modes (free-run, periodic, one-shot), per-channel sticky interrupt status with mask and clear, and a combined interrupt line to the core interrupt controller.

Parameters:
NUM_CH, 4, number of independent timer channels (1..16)
CNT_W, 32, counter width in bits (8..32)
PRESC_W, 8, prescaler compare width in bits

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
prescale  input  PRESC_W  shared tick divider; tick every prescale+1 cycles
ch_enable  input  NUM_CH  per-channel run enable (level)
ch_mode  input  2*NUM_CH  per-channel mode, 2 bits each: 00 free-run, 01 periodic, 10 one-shot, 11 treated as 01
ch_load_count  input  NUM_CH*CNT_W  per-channel reload value; channel i at [i*CNT_W +: CNT_W]
irq_mask  input  NUM_CH  1 = channel status contributes to interrupt
irq_clear  input  NUM_CH  1-cycle pulse; clears the channel's status bit
ch_current_value  output  NUM_CH*CNT_W  live counter values, same packing as ch_load_count
ch_done  output  NUM_CH  one-shot channel has expired and stopped
irq_status  output  NUM_CH  sticky raw expiry status (unmasked)
interrupt  output  1  OR over (irq_status & irq_mask)

Behaviour:
- Reset: every counter = all-ones, prescaler count = 0, enable history = 0, irq_status = 0, ch_done = 0, interrupt = 0.
- Prescaler:
  - Runs only while any ch_enable bit is 1. When all enables are 0, it is forced to 0.
  - tick = 1 in the cycle where the prescaler count equals prescale; the count then wraps to 0.
  - prescale = 0 gives a tick every cycle.
  - prescale is sampled live; if it is lowered below the current count, the count runs up to its max, wraps to 0, then matches the new value.
- Per channel, priority order within a cycle:
  1. Load (ch_enable=1 and previous-cycle enable=0): counter <= ch_load_count (modes 01/10/11) or all-ones (mode 00). Clear ch_done. Ignore tick this cycle (no decrement, no expiry).
  2. Stopped: ch_enable=0, or ch_done=1. Counter holds.
  3. Enabled, tick=1, counter != 0: counter <= counter - 1.
  4. Enabled, tick=1, counter == 0: expiry.
     - Modes 01/11: reload ch_load_count.
     - Mode 00: reload all-ones.
     - Mode 10: hold 0 and set ch_done.
  5. Enabled, tick=0: counter holds.
- Expiry timing and period:
  - An expiry sets irq_status[i] on the same clock edge.
  - Periodic period = load+1 ticks. Load 0 means expiry every tick.
  - Free-run period = 2^CNT_W ticks.
- ch_load_count changes while running take effect only at the next load or reload.
- Disable mid-count: counter freezes. Re-enable triggers a fresh load (rising edge), not a resume.
- irq_status:
  - Set on expiry; cleared by irq_clear.
  - Set wins over a simultaneous clear.
  - Stays set while the channel is disabled.
- interrupt is combinational from registered irq_status and irq_mask, so it is glitch-free. Masking a set status drops interrupt in the same cycle without clearing status.
- ch_done stays 1 until the next enable rising edge. Switching mode while done has no effect until reload.
- Reset asserted mid-operation returns all state to reset values immediately.

Test Plan:
- NUM_CH=2, CNT_W=8, prescale=0; ch0 mode 01, load 3; enable at cycle 0 -> counter 3,2,1,0,3,2,... from cycle 1; irq_status[0] sets at cycle 5, then every 4 cycles; interrupt follows with mask=1.
- prescale=2, ch0 mode 10, load 1 -> counter decrements only every 3rd cycle; single expiry; ch_done=1; counter holds 0; no further status sets; drop and raise enable -> counter=1, ch_done=0.
- ch1 mode 00, CNT_W=8, prescale=0 -> counter 255..0; expiry after 256 ticks; reload 255.
- irq_clear[0] pulse on the same cycle as a new ch0 expiry -> irq_status[0] stays 1. Clear on a non-expiry cycle -> 0 next cycle. irq_mask[0]=0 with status set -> interrupt=0, status=1.
- Disable ch0 at counter=5 for 10 cycles -> value stays 5. Change load to 9 while running in mode 01 -> takes effect only at next reload; re-enable edge reloads 9.
- Assert rstn low mid-count on both channels -> all counters 0xFF, status/done/interrupt 0. After release, channels reload only on a new enable rising edge.
